// File: rtl/resource_request_arbiter_pkg.sv
// Shared widths and FSM encoding for resource_request_arbiter and its bench.
//   ADDRESS_WIDTH / ID_WIDTH / DATA_WIDTH : request and response field widths
//   RESOURCE_DELAY                        : nominal shared_resource latency (cycles)
//   arb_state_e                           : issue FSM encoding (2-bit)
package resource_request_arbiter_pkg;

    localparam int unsigned ADDRESS_WIDTH  = 8;
    localparam int unsigned ID_WIDTH       = 4;
    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned RESOURCE_DELAY = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   req         in  2  request bits (bit N = port N)
//   last_grant  in  1  port granted most recently (state held by the parent)
//   grant_valid out 1  at least one request present
//   grant       out 1  winning port
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);

    always_comb begin
        grant_valid = |req;
        grant       = 1'b0;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/resource_request_arbiter.sv
// Upstream issue stage for shared_resource: two requesters, round-robin, one outstanding
// transaction, responses routed back to the owner; per-requester flush squashes that
// requester's pending and in-flight work without disturbing the resource.
//   clk, reset                       clock, synchronous active-high reset
//   reqN_valid/address/id, reqN_ready request slot N handshake
//   flushN                           squash requester N
//   rspN_valid/data/id               one-cycle response pulse to requester N
//   res_valid/address/id             issue to shared_resource
//   res_data_in/id_in/valid_in/ready_in  from shared_resource
//   err_timeout, err_id              sticky error flags
module resource_request_arbiter
    import resource_request_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_WIDTH       = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_address,
    input  logic [ID_WIDTH-1:0]      req0_id,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_address,
    input  logic [ID_WIDTH-1:0]      req1_id,
    output logic                     req1_ready,
    input  logic                     flush0,
    input  logic                     flush1,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_data,
    output logic [ID_WIDTH-1:0]      rsp0_id,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_data,
    output logic [ID_WIDTH-1:0]      rsp1_id,
    output logic                     res_valid,
    output logic [ADDRESS_WIDTH-1:0] res_address,
    output logic [ID_WIDTH-1:0]      res_id,
    input  logic [DATA_WIDTH-1:0]    res_data_in,
    input  logic [ID_WIDTH-1:0]      res_id_in,
    input  logic                     res_valid_in,
    input  logic                     res_ready_in,
    output logic                     err_timeout,
    output logic                     err_id
);

    arb_state_e               state;
    logic [1:0]               slot_full;
    logic [ADDRESS_WIDTH-1:0] slot_address [2];
    logic [ID_WIDTH-1:0]      slot_id      [2];
    logic [ADDRESS_WIDTH-1:0] req_address  [2];
    logic [ID_WIDTH-1:0]      req_id       [2];
    logic [1:0]               req_valid;
    logic [1:0]               flush;
    logic [1:0]               arb_req;
    logic                     last_grant;
    logic                     grant_valid;
    logic                     grant;
    logic                     owner;
    logic                     squash;
    logic                     can_issue;
    logic                     owner_flush;
    logic [TO_WIDTH-1:0]      timer;

    assign req_valid      = {req1_valid, req0_valid};
    assign flush          = {flush1, flush0};
    assign req_address[0] = req0_address;
    assign req_address[1] = req1_address;
    assign req_id[0]      = req0_id;
    assign req_id[1]      = req1_id;
    assign req0_ready     = ~slot_full[0];
    assign req1_ready     = ~slot_full[1];

    // A flushed slot must not be granted in the same cycle.
    assign arb_req     = slot_full & ~flush;
    assign can_issue   = (state == ARB_IDLE) && grant_valid && res_ready_in && !res_valid_in;
    assign owner_flush = flush[owner];

    rr_arbiter2 u_rr_arbiter2 (
        .req         (arb_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Request slots: flush clears and blocks acceptance in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full <= '0;
            for (int p = 0; p < 2; p++) begin
                slot_address[p] <= '0;
                slot_id[p]      <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (flush[p] || (can_issue && (grant == 1'(p)))) begin
                    slot_full[p] <= 1'b0;
                end else if (req_valid[p] && !slot_full[p]) begin
                    slot_full[p]    <= 1'b1;
                    slot_address[p] <= req_address[p];
                    slot_id[p]      <= req_id[p];
                end
            end
        end
    end

    // Issue FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            last_grant  <= 1'b1;  // port 0 wins the first tie
            owner       <= 1'b0;
            squash      <= 1'b0;
            timer       <= '0;
            res_valid   <= 1'b0;
            res_address <= '0;
            res_id      <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp0_id     <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_data   <= '0;
            rsp1_id     <= '0;
            err_timeout <= 1'b0;
            err_id      <= 1'b0;
        end else begin
            res_valid  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    squash <= 1'b0;
                    if (can_issue) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        res_address <= slot_address[grant];
                        res_id      <= slot_id[grant];
                        res_valid   <= 1'b1;
                        state       <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (owner_flush) squash <= 1'b1;
                    timer <= '0;
                    state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (owner_flush) squash <= 1'b1;
                    // Once timed out the block parks here until reset.
                    if (!err_timeout) begin
                        if (res_valid_in) begin
                            // A flush arriving with the first response still squashes it.
                            if (!squash && !owner_flush) begin
                                if (owner) begin
                                    rsp1_valid <= 1'b1;
                                    rsp1_data  <= res_data_in;
                                    rsp1_id    <= res_id;
                                end else begin
                                    rsp0_valid <= 1'b1;
                                    rsp0_data  <= res_data_in;
                                    rsp0_id    <= res_id;
                                end
                            end
                            if (res_id_in != res_id) err_id <= 1'b1;
                            state <= ARB_DRAIN;
                        end else begin
                            timer <= timer + TO_WIDTH'(1);
                            if (timer == TO_WIDTH'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;
                        end
                    end
                end
                ARB_DRAIN: begin
                    // Resource holds out_valid for several cycles; wait for it to re-arm.
                    if (!res_valid_in) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
